tl_ul_reg_bridge: RTL and testbench
===================================

Name: tl_ul_reg_bridge

Overview:
- Single-outstanding TileLink-UL slave that converts A-channel Get/PutFullData/PutPartialData requests into a one-cycle register strobe interface.
- Sits directly upstream of the Ethernet framing register file. It drives addr/en/we/wdata/be into the framing block and returns rdata on the D channel.
- Rejects unsupported opcodes and misaligned accesses with a denied response. These rejected requests never touch the register side.

Parameters:
- ADDR_WIDTH, 64, A-channel address and addr_o width.
- DATA_WIDTH, 64, data width; mask/be width is DATA_WIDTH/8.
- SRC_WIDTH, 4, a_source/d_source width.

Ports:
- clk_i  in  1  bus/register clock; only clock.
- rst_ni  in  1  asynchronous active-low reset.
- a_valid_i  in  1  A-channel valid.
- a_ready_o  out  1  A-channel ready.
- a_opcode_i  in  3  0=PutFullData, 1=PutPartialData, 4=Get; all others unsupported.
- a_size_i  in  3  log2(bytes).
- a_source_i  in  SRC_WIDTH  request ID.
- a_address_i  in  ADDR_WIDTH  byte address.
- a_mask_i  in  DATA_WIDTH/8  byte lanes.
- a_data_i  in  DATA_WIDTH  write data.
- d_valid_o  out  1  D-channel valid.
- d_ready_i  in  1  D-channel ready.
- d_opcode_o  out  3  0=AccessAck, 1=AccessAckData.
- d_size_o  out  3  echo of a_size.
- d_source_o  out  SRC_WIDTH  echo of a_source.
- d_denied_o  out  1  error response.
- d_data_o  out  DATA_WIDTH  read data; 0 for writes and denied responses.
- addr_o  out  ADDR_WIDTH  register address.
- en_o  out  1  one-cycle access strobe.
- we_o  out  1  write qualifier, valid only with en_o.
- wdata_o  out  DATA_WIDTH  write data.
- be_o  out  DATA_WIDTH/8  byte enables.
- rdata_i  in  DATA_WIDTH  register read data, valid exactly 1 cycle after en_o.

Behaviour:
- Reset (async assert, sync deassert internally):
  - state=IDLE.
  - All outputs 0, except a_ready_o=1.
  - Any in-flight transaction is discarded and no D response is issued for it.
- FSM states: IDLE, ACCESS, CAPTURE, RESP.
- IDLE:
  - a_ready_o=1.
  - On a_valid_i, latch opcode, size, source, address, mask and data.
  - Decode the request:
    - Supported: opcode in {0,1,4}, 2^size <= DATA_WIDTH/8, and address aligned to 2^size. Go to ACCESS.
    - Otherwise: set denied, go to RESP with no register access.
- ACCESS (one cycle):
  - en_o=1; we_o=1 for Put*, 0 for Get.
  - addr_o = latched address; wdata_o = latched data; be_o = latched mask. For Get, be_o=mask too.
  - Next state: CAPTURE.
- CAPTURE (one cycle):
  - en_o=0.
  - For Get, register rdata_i into d_data; for Put, d_data=0.
  - Next state: RESP.
- RESP:
  - d_valid_o=1; all d_* fields are held stable until d_ready_i.
  - d_opcode: AccessAckData for Get (including a denied Get), AccessAck otherwise.
  - On d_ready_i: next state IDLE, d_valid_o=0 the following cycle.
- a_ready_o=0 in every state except IDLE, so there is at most one outstanding request.
- Minimum latency: A handshake at cycle N gives en_o at N+1 and d_valid_o at N+3. A denied request gives d_valid_o at N+1.
- addr_o/wdata_o/be_o are held at their latched values outside ACCESS; the consumer must qualify them with en_o only.
- d_ready_i may already be high when d_valid_o rises; the handshake then completes in that first RESP cycle.
- Back-to-back: a new A beat is accepted no earlier than the cycle after the D handshake, when the FSM is back in IDLE.
- PutFullData with a partial mask is not checked; the mask is forwarded as-is.

Test Plan:
- Get at 0x1000, size=3, source=5; rdata_i=0xDEADBEEF_01234567 the cycle after en_o -> exactly one en_o pulse with we_o=0, be_o=0xFF. Response: d_opcode=1, d_source=5, d_size=3, d_denied=0, d_data=0xDEADBEEF_01234567, d_valid at N+3.
- PutPartialData at 0x0808, size=2, mask=0xF0, data=0x11223344_00000000 -> en_o=we_o=1 for one cycle, be_o=0xF0, addr_o=0x0808. Response: d_opcode=0, d_data=0.
- d_ready_i held low for 10 cycles after d_valid_o -> d_* fields stable, a_ready_o=0, and a new a_valid is ignored until after the handshake.
- Opcode 2 (Arithmetic), then Get with size=3 at address 0x1004 -> no en_o pulse for either. Arithmetic gets d_denied=1, d_opcode=0; misaligned Get gets d_denied=1, d_opcode=1, d_data=0.
- Two Gets issued back-to-back with d_ready_i=1 -> the second A handshake occurs the cycle after the first D handshake, with both source IDs returned in order.
- rst_ni asserted while in CAPTURE -> all outputs reset immediately (a_ready_o=1, d_valid_o=0, en_o=0). No response follows after release, and the next Get completes normally.

Source files
------------

// File: rtl/tl_ul_reg_bridge.sv
// Single-outstanding TileLink-UL slave that turns A-channel Get/Put beats into a
// one-cycle register strobe (en/we/addr/wdata/be) and answers on the D channel.
module tl_ul_reg_bridge #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int SRC_WIDTH  = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    a_valid_i,
  output logic                    a_ready_o,
  input  logic [2:0]              a_opcode_i,
  input  logic [2:0]              a_size_i,
  input  logic [SRC_WIDTH-1:0]    a_source_i,
  input  logic [ADDR_WIDTH-1:0]   a_address_i,
  input  logic [DATA_WIDTH/8-1:0] a_mask_i,
  input  logic [DATA_WIDTH-1:0]   a_data_i,
  output logic                    d_valid_o,
  input  logic                    d_ready_i,
  output logic [2:0]              d_opcode_o,
  output logic [2:0]              d_size_o,
  output logic [SRC_WIDTH-1:0]    d_source_o,
  output logic                    d_denied_o,
  output logic [DATA_WIDTH-1:0]   d_data_o,
  output logic [ADDR_WIDTH-1:0]   addr_o,
  output logic                    en_o,
  output logic                    we_o,
  output logic [DATA_WIDTH-1:0]   wdata_o,
  output logic [DATA_WIDTH/8-1:0] be_o,
  input  logic [DATA_WIDTH-1:0]   rdata_i
);

  localparam int         MASK_W   = DATA_WIDTH / 8;
  localparam logic [2:0] MAX_SIZE = 3'($clog2(MASK_W));

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

  state_t     state;
  logic       is_get;
  logic [1:0] rst_sync;
  logic       rst_n;

  function automatic logic supported(input logic [2:0]            op,
                                     input logic [2:0]            size,
                                     input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] low_bits;
    low_bits = ~({ADDR_WIDTH{1'b1}} << size);
    return ((op == 3'd0) || (op == 3'd1) || (op == 3'd4)) &&
           (size <= MAX_SIZE) && ((addr & low_bits) == '0);
  endfunction

  // Reset asserts asynchronously but releases on a clock edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rst_sync <= 2'b00;
    else         rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      is_get     <= 1'b0;
      a_ready_o  <= 1'b1;
      d_valid_o  <= 1'b0;
      d_opcode_o <= '0;
      d_size_o   <= '0;
      d_source_o <= '0;
      d_denied_o <= 1'b0;
      d_data_o   <= '0;
      addr_o     <= '0;
      en_o       <= 1'b0;
      we_o       <= 1'b0;
      wdata_o    <= '0;
      be_o       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (a_valid_i) begin
            a_ready_o  <= 1'b0;
            is_get     <= (a_opcode_i == 3'd4);
            addr_o     <= a_address_i;
            wdata_o    <= a_data_i;
            be_o       <= a_mask_i;
            d_size_o   <= a_size_i;
            d_source_o <= a_source_i;
            d_opcode_o <= {2'b00, a_opcode_i == 3'd4};
            if (supported(a_opcode_i, a_size_i, a_address_i)) begin
              en_o       <= 1'b1;
              we_o       <= (a_opcode_i != 3'd4);
              d_denied_o <= 1'b0;
              state      <= ACCESS;
            end else begin
              // Rejected beats skip the register side entirely.
              d_denied_o <= 1'b1;
              d_data_o   <= '0;
              d_valid_o  <= 1'b1;
              state      <= RESP;
            end
          end
        end
        ACCESS: begin
          en_o  <= 1'b0;
          we_o  <= 1'b0;
          state <= CAPTURE;
        end
        CAPTURE: begin
          d_data_o  <= is_get ? rdata_i : '0;
          d_valid_o <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (d_ready_i) begin
            d_valid_o <= 1'b0;
            a_ready_o <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tl_ul_reg_bridge.sv
// Directed bench for tl_ul_reg_bridge: Get, Put with back-pressure, denied
// requests, back-to-back Gets and reset during an access.
module tb_tl_ul_reg_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, a_ready;
  logic [2:0]  a_opcode, a_size;
  logic [3:0]  a_source;
  logic [63:0] a_address;
  logic [7:0]  a_mask;
  logic [63:0] a_data;
  logic        d_valid, d_ready;
  logic [2:0]  d_opcode, d_size;
  logic [3:0]  d_source;
  logic        d_denied;
  logic [63:0] d_data;
  logic [63:0] addr;
  logic        en, we;
  logic [63:0] wdata;
  logic [7:0]  be;
  logic [63:0] rdata;

  int total = 0;
  int bad   = 0;
  int en_cnt = 0;
  int dv_cnt = 0;
  int e0, dv0;

  tl_ul_reg_bridge #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .SRC_WIDTH(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .a_valid_i(a_valid), .a_ready_o(a_ready), .a_opcode_i(a_opcode),
    .a_size_i(a_size), .a_source_i(a_source), .a_address_i(a_address),
    .a_mask_i(a_mask), .a_data_i(a_data),
    .d_valid_o(d_valid), .d_ready_i(d_ready), .d_opcode_o(d_opcode),
    .d_size_o(d_size), .d_source_o(d_source), .d_denied_o(d_denied),
    .d_data_o(d_data),
    .addr_o(addr), .en_o(en), .we_o(we), .wdata_o(wdata), .be_o(be),
    .rdata_i(rdata)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (en)      en_cnt++;
    if (d_valid) dv_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_a(input logic [2:0] op, input logic [2:0] sz, input logic [3:0] src,
                       input logic [63:0] ad, input logic [7:0] mk, input logic [63:0] dt);
    a_valid = 1'b1; a_opcode = op; a_size = sz; a_source = src;
    a_address = ad; a_mask = mk; a_data = dt;
  endtask

  initial begin
    rst_n = 1'b0; a_valid = 1'b0; a_opcode = '0; a_size = '0; a_source = '0;
    a_address = '0; a_mask = '0; a_data = '0; d_ready = 1'b0; rdata = '0;
    #12;
    chk("rst_a_ready", a_ready, 1);
    chk("rst_d_valid", d_valid, 0);
    chk("rst_en", en, 0);
    chk("rst_addr", addr, 0);
    chk("rst_d_data", d_data, 0);
    rst_n = 1'b1;
    repeat (4) tick;

    // Get 0x1000 size 3 source 5
    e0 = en_cnt;
    set_a(3'd4, 3'd3, 4'd5, 64'h1000, 8'hFF, 64'h0);
    chk("get_a_ready", a_ready, 1);
    tick; a_valid = 1'b0;
    chk("get_en", en, 1);
    chk("get_we", we, 0);
    chk("get_be", be, 8'hFF);
    chk("get_addr", addr, 64'h1000);
    chk("get_a_ready_busy", a_ready, 0);
    chk("get_dv_n1", d_valid, 0);
    tick; rdata = 64'hDEADBEEF_01234567;
    chk("get_en_n2", en, 0);
    chk("get_dv_n2", d_valid, 0);
    tick; rdata = 64'h5A5A5A5A_5A5A5A5A;
    chk("get_dv_n3", d_valid, 1);
    chk("get_opcode", d_opcode, 1);
    chk("get_source", d_source, 5);
    chk("get_size", d_size, 3);
    chk("get_denied", d_denied, 0);
    chk("get_data", d_data, 64'hDEADBEEF_01234567);
    chk("get_en_pulses", 64'(en_cnt - e0), 1);
    d_ready = 1'b1;
    tick; d_ready = 1'b0;
    chk("get_dv_done", d_valid, 0);
    chk("get_idle_ready", a_ready, 1);

    // PutPartialData with 10 cycles of D back-pressure
    e0 = en_cnt;
    set_a(3'd1, 3'd2, 4'd3, 64'h0808, 8'hF0, 64'h11223344_00000000);
    tick; a_valid = 1'b0;
    chk("put_en", en, 1);
    chk("put_we", we, 1);
    chk("put_be", be, 8'hF0);
    chk("put_addr", addr, 64'h0808);
    chk("put_wdata", wdata, 64'h11223344_00000000);
    tick; rdata = 64'h0000_0777;
    chk("put_en_n2", en, 0);
    tick;
    chk("put_dv", d_valid, 1);
    chk("put_opcode", d_opcode, 0);
    chk("put_data", d_data, 0);
    chk("put_source", d_source, 3);
    chk("put_size", d_size, 2);
    set_a(3'd4, 3'd3, 4'd9, 64'h40, 8'hFF, 64'h0);
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("stall_dv", d_valid, 1);
      chk("stall_source", d_source, 3);
      chk("stall_data", d_data, 0);
      chk("stall_a_ready", a_ready, 0);
    end
    chk("stall_en_pulses", 64'(en_cnt - e0), 1);
    d_ready = 1'b1;
    tick; d_ready = 1'b0;
    chk("stall_dv_done", d_valid, 0);
    chk("stall_idle_ready", a_ready, 1);
    tick; a_valid = 1'b0;
    chk("pend_en", en, 1);
    chk("pend_addr", addr, 64'h40);
    tick; rdata = 64'h0000_CAFE;
    tick;
    chk("pend_dv", d_valid, 1);
    chk("pend_source", d_source, 9);
    chk("pend_data", d_data, 64'h0000_CAFE);

    // Back-to-back Gets with d_ready held high
    d_ready = 1'b1;
    tick;
    set_a(3'd4, 3'd3, 4'd2, 64'h10, 8'hFF, 64'h0);
    tick;
    a_source = 4'd7; a_address = 64'h18;
    chk("b2b_en1", en, 1);
    chk("b2b_busy", a_ready, 0);
    tick; rdata = 64'hAAAA_AAAA_AAAA_AAAA;
    tick;
    chk("b2b_dv1", d_valid, 1);
    chk("b2b_src1", d_source, 2);
    chk("b2b_data1", d_data, 64'hAAAA_AAAA_AAAA_AAAA);
    tick;
    chk("b2b_dv_gap", d_valid, 0);
    chk("b2b_ready_gap", a_ready, 1);
    chk("b2b_en_gap", en, 0);
    tick; a_valid = 1'b0;
    chk("b2b_en2", en, 1);
    chk("b2b_addr2", addr, 64'h18);
    tick; rdata = 64'hBBBB_BBBB_BBBB_BBBB;
    tick;
    chk("b2b_dv2", d_valid, 1);
    chk("b2b_src2", d_source, 7);
    chk("b2b_data2", d_data, 64'hBBBB_BBBB_BBBB_BBBB);
    tick; d_ready = 1'b0;
    chk("b2b_dv_done", d_valid, 0);

    // Denied requests never strobe the register side
    e0 = en_cnt;
    set_a(3'd2, 3'd3, 4'd1, 64'h20, 8'hFF, 64'h0);
    tick; a_valid = 1'b0;
    chk("arith_dv", d_valid, 1);
    chk("arith_denied", d_denied, 1);
    chk("arith_opcode", d_opcode, 0);
    chk("arith_data", d_data, 0);
    d_ready = 1'b1;
    tick; d_ready = 1'b0;
    chk("arith_dv_done", d_valid, 0);
    set_a(3'd4, 3'd3, 4'd6, 64'h1004, 8'hFF, 64'h0);
    tick; a_valid = 1'b0;
    chk("misal_dv", d_valid, 1);
    chk("misal_denied", d_denied, 1);
    chk("misal_opcode", d_opcode, 1);
    chk("misal_data", d_data, 0);
    chk("misal_source", d_source, 6);
    d_ready = 1'b1;
    tick;
    set_a(3'd4, 3'd4, 4'd8, 64'h0, 8'hFF, 64'h0);
    tick; a_valid = 1'b0;
    chk("big_denied", d_denied, 1);
    chk("big_dv", d_valid, 1);
    tick; d_ready = 1'b0;
    chk("denied_no_en", 64'(en_cnt - e0), 0);

    // Reset while in CAPTURE
    set_a(3'd4, 3'd3, 4'd4, 64'h100, 8'hFF, 64'h0);
    tick; a_valid = 1'b0;
    tick; rdata = 64'h1234;
    #1 rst_n = 1'b0;
    #1;
    chk("rstc_a_ready", a_ready, 1);
    chk("rstc_d_valid", d_valid, 0);
    chk("rstc_en", en, 0);
    chk("rstc_addr", addr, 0);
    tick; rst_n = 1'b1;
    dv0 = dv_cnt;
    d_ready = 1'b1;
    repeat (5) tick;
    chk("rstc_no_resp", 64'(dv_cnt - dv0), 0);
    chk("rstc_idle", a_ready, 1);
    d_ready = 1'b0;
    set_a(3'd4, 3'd3, 4'd11, 64'h200, 8'hFF, 64'h0);
    tick; a_valid = 1'b0;
    chk("post_en", en, 1);
    chk("post_addr", addr, 64'h200);
    tick; rdata = 64'h99;
    tick;
    chk("post_dv", d_valid, 1);
    chk("post_source", d_source, 11);
    chk("post_data", d_data, 64'h99);
    chk("post_denied", d_denied, 0);
    d_ready = 1'b1;
    tick; d_ready = 1'b0;
    chk("post_done", d_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
